// File: rtl/hdmi_pkg.sv
// Shared display-path definitions: channel width default, RGB record,
// default palette contents and the underflow grey colour.
package hdmi_pkg;

  localparam int unsigned COLOR_W_DEFAULT = 8;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  localparam rgb_t UNDERFLOW_GREY = '{red: 8'd127, green: 8'd127, blue: 8'd127};

  // Default palette entry; indices beyond the first eight read as grey.
  function automatic rgb_t default_entry(input int unsigned idx);
    case (idx)
      0:       return '{red: 8'd0,   green: 8'd0,   blue: 8'd0};
      1:       return '{red: 8'd219, green: 8'd32,  blue: 8'd62};
      2:       return '{red: 8'd77,  green: 8'd25,  blue: 8'd27};
      3:       return '{red: 8'd168, green: 8'd176, blue: 8'd67};
      4:       return '{red: 8'd43,  green: 8'd51,  blue: 8'd20};
      5:       return '{red: 8'd255, green: 8'd169, blue: 8'd0};
      6:       return '{red: 8'd71,  green: 8'd40,  blue: 8'd18};
      7:       return '{red: 8'd255, green: 8'd255, blue: 8'd255};
      default: return UNDERFLOW_GREY;
    endcase
  endfunction

endpackage

// File: rtl/pixel_word_fifo.sv
// Two-entry packed-word buffer with push, pop and flush. A push in a flush
// cycle survives the flush; flush has priority over pop.
module pixel_word_fifo #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem0;
  logic [WORD_W-1:0] mem1;

  assign head = mem0;

  // Storage and occupancy update; mem0 is always the head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      mem0  <= '0;
      mem1  <= '0;
    end else if (flush) begin
      count <= push ? 2'd1 : 2'd0;
      if (push) mem0 <= push_data;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            mem0 <= mem1;
            mem1 <= push_data;
          end else begin
            mem0 <= push_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) mem0 <= push_data;
          else               mem1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/palette_pixel_pipe.sv
// Palette pixel pipeline: unpacks indexed pixels from buffered words and
// maps them through a palette, two cycles from draw_area to colour.
// Build option: define PALETTE_WR_EN for a writable palette; otherwise the
// palette is a constant table and the pal_* ports are ignored.
module palette_pixel_pipe #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned BPP     = 4,
  parameter int unsigned COLOR_W = hdmi_pkg::COLOR_W_DEFAULT
) (
  input  logic                 pixclk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 draw_area,
  input  logic [WORD_W-1:0]    word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic                 pal_we,
  input  logic [BPP-1:0]       pal_addr,
  input  logic [3*COLOR_W-1:0] pal_wdata,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 underflow
);
  import hdmi_pkg::*;

  localparam int unsigned PIX         = WORD_W / BPP;
  localparam int unsigned POS_W       = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int unsigned NUM_ENTRIES = 2 ** BPP;

  // Fit an 8-bit constant to COLOR_W: keep the top bits or pad at the LSB.
  function automatic logic [3*COLOR_W-1:0] scale(input rgb_t c);
    logic [COLOR_W+7:0] r, g, b;
    r = {c.red,   {COLOR_W{1'b0}}};
    g = {c.green, {COLOR_W{1'b0}}};
    b = {c.blue,  {COLOR_W{1'b0}}};
    return {r[COLOR_W+7 -: COLOR_W], g[COLOR_W+7 -: COLOR_W], b[COLOR_W+7 -: COLOR_W]};
  endfunction

  logic [WORD_W-1:0]  head;
  logic [1:0]         count;
  logic [POS_W-1:0]   pos;
  logic               have, last, consume, pop, push;
  logic [BPP-1:0]     idx;
  logic               s1_draw, s1_empty;
  logic [BPP-1:0]     s1_idx;
  logic [3*COLOR_W-1:0] pal_rd;

  assign have       = (count != 2'd0);
  assign last       = (pos == POS_W'(PIX - 1));
  assign consume    = draw_area && have;
  assign pop        = consume && last && !frame_start;
  assign word_ready = !rst && ((count < 2'd2) || pop || frame_start);
  assign push       = word_valid && word_ready;

  pixel_word_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clk       (pixclk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (push),
    .push_data (word_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Select the current pixel index from the head word.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < PIX; i++)
      if (pos == POS_W'(i)) idx = head[i*BPP +: BPP];
  end

  // Pixel position within the head word and sticky underflow flag.
  always_ff @(posedge pixclk) begin
    if (rst || frame_start) begin
      pos       <= '0;
      underflow <= 1'b0;
    end else begin
      if (consume) pos <= last ? '0 : pos + POS_W'(1);
      if (draw_area && !have) underflow <= 1'b1;
    end
  end

  // Stage 1: capture visibility, buffer state and index.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      s1_draw  <= 1'b0;
      s1_empty <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_draw  <= draw_area;
      s1_empty <= !have;
      s1_idx   <= idx;
    end
  end

`ifdef PALETTE_WR_EN
  logic [3*COLOR_W-1:0] pal [NUM_ENTRIES];

  // Writable palette, reloaded with defaults on reset; reads see old data.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++)
        pal[i[BPP-1:0]] <= scale(default_entry(i));
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  assign pal_rd = pal[s1_idx];
`else
  logic pal_unused;
  assign pal_unused = ^{pal_we, pal_addr, pal_wdata};
  assign pal_rd     = scale(default_entry(32'(s1_idx)));
`endif

  // Stage 2: registered colour output.
  always_ff @(posedge pixclk) begin
    if (rst || !s1_draw) begin
      {red, green, blue} <= '0;
    end else if (s1_empty) begin
      {red, green, blue} <= scale(UNDERFLOW_GREY);
    end else begin
      {red, green, blue} <= pal_rd;
    end
  end

endmodule

// File: tb/tb_palette_pixel_pipe.sv
// Self-checking bench for palette_pixel_pipe: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_palette_pixel_pipe;

  logic        pixclk = 1'b0;
  logic        rst, frame_start, draw_area, word_valid, word_ready;
  logic [15:0] word_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [7:0]  red, green, blue;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] q[$];
  int          pos;
  bit          und;
  logic [23:0] exp_rgb;
  bit          p1_draw, p1_empty;
  logic [3:0]  p1_idx;
  logic [23:0] pal [16];

  always #5 pixclk = ~pixclk;

  palette_pixel_pipe #(.WORD_W(16), .BPP(4), .COLOR_W(8)) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .frame_start (frame_start),
    .draw_area   (draw_area),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .underflow   (underflow)
  );

  function automatic logic [23:0] def_color(input int i);
    case (i)
      0: return {8'd0,   8'd0,   8'd0};
      1: return {8'd219, 8'd32,  8'd62};
      2: return {8'd77,  8'd25,  8'd27};
      3: return {8'd168, 8'd176, 8'd67};
      4: return {8'd43,  8'd51,  8'd20};
      5: return {8'd255, 8'd169, 8'd0};
      6: return {8'd71,  8'd40,  8'd18};
      7: return {8'd255, 8'd255, 8'd255};
      default: return {8'd127, 8'd127, 8'd127};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos = 0;
    und = 1'b0;
    exp_rgb = '0;
    p1_draw = 1'b0;
    p1_empty = 1'b0;
    p1_idx = '0;
    for (int i = 0; i < 16; i++) pal[i] = def_color(i);
  endtask

  // One pixel clock: drive inputs, check at the falling edge, advance model.
  task automatic step(input bit r, input bit fs, input bit dr, input bit wv,
                      input logic [15:0] wd, input bit we, input logic [3:0] wa,
                      input logic [23:0] wdt);
    bit exp_ready, push;
    rst = r; frame_start = fs; draw_area = dr; word_valid = wv; word_data = wd;
    pal_we = we; pal_addr = wa; pal_wdata = wdt;
    @(negedge pixclk);
    exp_ready = !r && (q.size() < 2 || fs || (dr && q.size() > 0 && pos == 3));
    chk("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb});
    chk("underflow", {31'h0, underflow}, {31'h0, und});
    chk("word_ready", {31'h0, word_ready}, {31'h0, exp_ready});
    if (r) begin
      model_reset();
    end else begin
      exp_rgb = !p1_draw ? 24'h0 : (p1_empty ? 24'h7f7f7f : pal[p1_idx]);
      p1_draw  = dr;
      p1_empty = (q.size() == 0);
      p1_idx   = (q.size() > 0) ? 4'((q[0] >> (4 * pos)) & 16'hf) : 4'h0;
`ifdef PALETTE_WR_EN
      if (we) pal[wa] = wdt;
`endif
      push = wv && exp_ready;
      if (fs) begin
        q.delete();
        if (push) q.push_back(wd);
        pos = 0;
        und = 1'b0;
      end else begin
        if (dr && q.size() > 0) begin
          pos++;
          if (pos == 4) begin
            void'(q.pop_front());
            pos = 0;
          end
        end else if (dr) begin
          und = 1'b1;
        end
        if (push) q.push_back(wd);
      end
    end
    @(posedge pixclk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 16'h0, 0, 4'h0, 24'h0);
  endtask

  task automatic draw(input bit wv, input logic [15:0] wd);
    step(0, 0, 1, wv, wd, 0, 4'h0, 24'h0);
  endtask

  task automatic push_word(input logic [15:0] wd);
    step(0, 0, 0, 1, wd, 0, 4'h0, 24'h0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; frame_start = 1'b0; draw_area = 1'b0; word_valid = 1'b0;
    word_data = '0; pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
    @(posedge pixclk);
    #1;
    step(1, 0, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    step(1, 0, 0, 0, 16'h0, 0, 4'h0, 24'h0);

    // One word, four pixels in bit order 1,3,5,7
    push_word(16'h7531);
    draw(0, 16'h0);
    draw(0, 16'h0);
    chk("px0", {8'h0, red, green, blue}, 32'h00db203e);
    draw(0, 16'h0);
    chk("px1", {8'h0, red, green, blue}, 32'h00a8b043);
    draw(0, 16'h0);
    chk("px2", {8'h0, red, green, blue}, 32'h00ffa900);
    idle();
    chk("px3", {8'h0, red, green, blue}, 32'h00ffffff);
    idle();

    // Continuous drawing across word boundaries with an always-valid source
    push_word(16'h2222);
    push_word(16'h3333);
    for (int i = 0; i < 20; i++) draw(1, 16'(16'h4444 + i));
    chk("no_underflow_stream", {31'h0, underflow}, 32'h0);

    // Empty buffer: grey output and sticky underflow
    step(0, 1, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    draw(0, 16'h0);
    idle();
    chk("grey", {8'h0, red, green, blue}, 32'h007f7f7f);
    chk("underflow_set", {31'h0, underflow}, 32'h1);
    idle();
    idle();
    chk("underflow_sticky", {31'h0, underflow}, 32'h1);

    // frame_start mid-word keeps only the word offered alongside it
    push_word(16'h4444);
    draw(0, 16'h0);
    draw(0, 16'h0);
    step(0, 1, 0, 1, 16'h0001, 0, 4'h0, 24'h0);
    draw(0, 16'h0);
    idle();
    chk("after_flush_px", {8'h0, red, green, blue}, 32'h00db203e);
    chk("after_flush_underflow", {31'h0, underflow}, 32'h0);

    // Palette write racing a read of the same entry
    step(0, 1, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    push_word(16'h1111);
    draw(0, 16'h0);
    step(0, 0, 1, 0, 16'h0, 1, 4'h1, 24'h102030);
    chk("pal_old", {8'h0, red, green, blue}, 32'h00db203e);
    draw(0, 16'h0);
`ifdef PALETTE_WR_EN
    chk("pal_new", {8'h0, red, green, blue}, 32'h00102030);
`else
    chk("pal_const", {8'h0, red, green, blue}, 32'h00db203e);
`endif

    // Reset with one and a half words buffered
    step(0, 1, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    push_word(16'h2345);
    push_word(16'h6702);
    draw(0, 16'h0);
    draw(0, 16'h0);
    step(1, 0, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    step(1, 0, 0, 0, 16'h0, 0, 4'h0, 24'h0);
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    draw(0, 16'h0);
    idle();
    chk("rst_emptied", {8'h0, red, green, blue}, 32'h007f7f7f);
    step(0, 1, 0, 1, 16'h0001, 0, 4'h0, 24'h0);
    draw(0, 16'h0);
    idle();
    chk("rst_palette", {8'h0, red, green, blue}, 32'h00db203e);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 1) == 1,
           16'($urandom),
           $urandom_range(0, 7) == 0,
           4'($urandom),
           24'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
